cache_wb_buffer: RTL and testbench

Single-entry write-back buffer for the data cache. Accepts one evicted dirty line, presented in parallel by the cache data RAM's replace-line port, and streams it to memory as a single-address burst write with valid/ready handshakes, one 32-bit word per beat. While a line is pending it reports address matches, so the refill path does not fetch stale data from memory.

---
 rtl/cache_wb_buffer_if.sv | 64 ++++++
 rtl/cache_wb_buffer.sv | 145 ++++++++++++++
 tb/tb_cache_wb_buffer.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_wb_buffer_if.sv
// Bundle of all handshake/bus signals around the write-back buffer.
//   Cache side : wb_req, wb_addr, wb_line (in), wb_ready (out)
//   Memory side: wr_req/wr_addr/wr_len (address), wr_ready (in)
//                wr_valid/wr_data/wr_strb/wr_last (data), wr_data_ready (in)
//                wr_bready (out), wr_bvalid (in) (write response)
//   Lookup     : chk_addr (in), chk_hit/chk_data (out)
//   Status     : busy (out)
// Modport slave is the buffer; modport master is the cache/memory environment.
interface cache_wb_buffer_if #(
    parameter int unsigned WORDS = 4
);
    logic                   wb_req;
    logic [31:0]            wb_addr;
    logic [WORDS*32-1:0]    wb_line;
    logic                   wb_ready;

    logic                   wr_req;
    logic [31:0]            wr_addr;
    logic [7:0]             wr_len;
    logic                   wr_ready;

    logic                   wr_valid;
    logic [31:0]            wr_data;
    logic [3:0]             wr_strb;
    logic                   wr_last;
    logic                   wr_data_ready;

    logic                   wr_bready;
    logic                   wr_bvalid;

    logic [31:0]            chk_addr;
    logic                   chk_hit;
    logic [31:0]            chk_data;

    logic                   busy;

    modport slave (
        input  wb_req, wb_addr, wb_line,
        output wb_ready,
        output wr_req, wr_addr, wr_len,
        input  wr_ready,
        output wr_valid, wr_data, wr_strb, wr_last,
        input  wr_data_ready,
        output wr_bready,
        input  wr_bvalid,
        input  chk_addr,
        output chk_hit, chk_data,
        output busy
    );

    modport master (
        output wb_req, wb_addr, wb_line,
        input  wb_ready,
        input  wr_req, wr_addr, wr_len,
        output wr_ready,
        input  wr_valid, wr_data, wr_strb, wr_last,
        output wr_data_ready,
        input  wr_bready,
        output wr_bvalid,
        output chk_addr,
        input  chk_hit, chk_data,
        input  busy
    );
endinterface

// File: rtl/cache_wb_buffer.sv
// Single-entry write-back buffer: captures one evicted dirty line and streams
// it to memory as a single-address burst (one 32-bit word per beat), while
// reporting address hits so the refill path never reads stale memory.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset
//   bus   - cache_wb_buffer_if.slave (cache offer, memory burst, lookup, busy)
// Optional feature macro: WB_FORWARD_EN - drives chk_data with the pending
// line word selected by chk_addr; otherwise chk_data is tied to 0.
module cache_wb_buffer #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned OFF_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    cache_wb_buffer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WORDS);
    localparam int unsigned TAG_W = 32 - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pending;
    logic [31:0]        r_words [WORDS];

    logic               r_wb_ready;
    logic               r_wr_req;
    logic [31:0]        r_wr_addr;
    logic               r_wr_valid;
    logic [31:0]        r_wr_data;
    logic               r_wr_last;
    logic               r_wr_bready;

    logic               w_beat;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_unused;

    assign w_beat    = r_wr_valid & bus.wr_data_ready;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);

    // Buffer FSM; every handshake output is a register updated on its transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pending   <= 1'b0;
            r_wb_ready  <= 1'b1;
            r_wr_req    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_data   <= '0;
            r_wr_last   <= 1'b0;
            r_wr_bready <= 1'b0;
            for (int i = 0; i < int'(WORDS); i++) begin
                r_words[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wb_req) begin
                        r_state    <= S_ADDR;
                        r_pending  <= 1'b1;
                        r_wb_ready <= 1'b0;
                        r_wr_req   <= 1'b1;
                        r_wr_addr  <= {bus.wb_addr[31:OFF_W], OFF_W'(0)};
                        for (int i = 0; i < int'(WORDS); i++) begin
                            r_words[i] <= bus.wb_line[i*32 +: 32];
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.wr_ready) begin
                        r_state    <= S_DATA;
                        r_wr_req   <= 1'b0;
                        r_wr_valid <= 1'b1;
                        r_cnt      <= '0;
                        r_wr_data  <= r_words[0];
                        r_wr_last  <= 1'b0;
                    end
                end
                S_DATA: begin
                    // Data and last are preloaded for the next beat so they
                    // stay stable while wr_data_ready is low.
                    if (w_beat) begin
                        r_cnt <= w_cnt_nxt;
                        if (r_wr_last) begin
                            r_state     <= S_RESP;
                            r_wr_valid  <= 1'b0;
                            r_wr_last   <= 1'b0;
                            r_wr_bready <= 1'b1;
                        end else begin
                            r_wr_data <= r_words[w_cnt_nxt];
                            r_wr_last <= (w_cnt_nxt == CNT_W'(WORDS - 1));
                        end
                    end
                end
                S_RESP: begin
                    if (bus.wr_bvalid) begin
                        r_state     <= S_IDLE;
                        r_pending   <= 1'b0;
                        r_wb_ready  <= 1'b1;
                        r_wr_bready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.wb_ready  = r_wb_ready;
    assign bus.busy      = r_pending;
    assign bus.wr_req    = r_wr_req;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_len    = 8'(WORDS - 1);
    assign bus.wr_valid  = r_wr_valid;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_strb   = r_wr_valid ? 4'hf : 4'h0;
    assign bus.wr_last   = r_wr_last;
    assign bus.wr_bready = r_wr_bready;

    // Hazard lookup: combinational tag compare against the pending line only.
    assign bus.chk_hit = r_pending &&
                         (bus.chk_addr[31:OFF_W] == r_wr_addr[31:OFF_W]);

`ifdef WB_FORWARD_EN
    // Word select straight from the lookup address so a refill can be served
    // from the buffer in the same cycle it hits.
    assign bus.chk_data = r_words[bus.chk_addr[OFF_W-1:2]];
`else
    assign bus.chk_data = 32'h0;
`endif

    // Byte-offset bits of the incoming addresses carry no information here.
    assign w_unused = ^{bus.wb_addr[OFF_W-1:0], bus.chk_addr[OFF_W-1:0],
                        TAG_W'(0)};
endmodule

// File: tb/tb_cache_wb_buffer.sv
module tb_cache_wb_buffer;
    localparam int unsigned WORDS = 4;
    localparam int unsigned OFF_W = 4;

    typedef struct packed {
        logic [31:0]              addr;
        logic [WORDS-1:0][31:0]   w;
    } line_t;

    logic clk;
    logic reset;

    cache_wb_buffer_if #(.WORDS(WORDS)) bus ();

    cache_wb_buffer #(.WORDS(WORDS), .OFF_W(OFF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Directed vs random memory-side / lookup drive
    logic        rand_rdy = 1'b0;
    logic        d_wr_ready = 1'b0, d_wr_data_ready = 1'b0, d_wr_bvalid = 1'b0;
    logic [31:0] d_chk_addr = '0;
    logic        r_wr_ready = 1'b0, r_wr_data_ready = 1'b0, r_wr_bvalid = 1'b0;
    logic [31:0] r_chk_addr = '0;

    assign bus.wr_ready      = rand_rdy ? r_wr_ready      : d_wr_ready;
    assign bus.wr_data_ready = rand_rdy ? r_wr_data_ready : d_wr_data_ready;
    assign bus.wr_bvalid     = rand_rdy ? r_wr_bvalid     : d_wr_bvalid;
    assign bus.chk_addr      = rand_rdy ? r_chk_addr      : d_chk_addr;

    // Scoreboard: lines offered to the buffer, in order
    line_t exp_q[$];

    // Reference model of the pending line's progress
    bit mon_en      = 1'b0;
    bit pending     = 1'b0;
    bit addr_done   = 1'b0;
    int beats       = 0;
    int lines_done  = 0;
    int beats_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    // Monitor: compare outputs against the model, then advance the model with
    // the handshakes that the next rising edge will complete.
    always @(negedge clk) begin
        if (mon_en) begin
            line_t cur;
            bit    exp_valid;
            cur = '0;
            if (pending) begin
                if (exp_q.size() == 0) timeout("scoreboard_empty");
                else cur = exp_q[0];
            end
            exp_valid = pending && addr_done && (beats < int'(WORDS));
            check("wb_ready", 32'(bus.wb_ready), 32'(!pending));
            check("busy", 32'(bus.busy), 32'(pending));
            check("wr_req", 32'(bus.wr_req), 32'(pending && !addr_done));
            if (pending && !addr_done) begin
                check("wr_addr", bus.wr_addr, cur.addr);
                check("wr_len", 32'(bus.wr_len), 32'(WORDS - 1));
            end
            check("wr_valid", 32'(bus.wr_valid), 32'(exp_valid));
            if (exp_valid) begin
                check("wr_data", bus.wr_data, cur.w[beats]);
                check("wr_last", 32'(bus.wr_last), 32'(beats == int'(WORDS) - 1));
                check("wr_strb", 32'(bus.wr_strb), 32'hf);
            end else begin
                check("wr_strb_idle", 32'(bus.wr_strb), 32'h0);
            end
            check("wr_bready", 32'(bus.wr_bready), 32'(pending && beats == int'(WORDS)));
            check("chk_hit", 32'(bus.chk_hit),
                  32'(pending && bus.chk_addr[31:OFF_W] == cur.addr[31:OFF_W]));
`ifdef WB_FORWARD_EN
            if (pending)
                check("chk_data", bus.chk_data, cur.w[bus.chk_addr[OFF_W-1:2]]);
`else
            check("chk_data_tied", bus.chk_data, 32'h0);
`endif
            if (reset) begin
                if (pending && exp_q.size() > 0) void'(exp_q.pop_front());
                pending   = 1'b0;
                addr_done = 1'b0;
                beats     = 0;
            end else if (!pending) begin
                if (bus.wb_req) begin
                    pending   = 1'b1;
                    addr_done = 1'b0;
                    beats     = 0;
                end
            end else if (!addr_done) begin
                if (bus.wr_ready) addr_done = 1'b1;
            end else if (beats < int'(WORDS)) begin
                if (bus.wr_data_ready) begin
                    beats++;
                    beats_total++;
                end
            end else if (bus.wr_bvalid) begin
                pending = 1'b0;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                lines_done++;
            end
        end
    end

    // Random memory-side readiness and lookup addresses
    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            r_wr_ready      = ($urandom_range(0, 3) != 0);
            r_wr_data_ready = ($urandom_range(0, 3) != 0);
            r_wr_bvalid     = ($urandom_range(0, 2) != 0);
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1)
                r_chk_addr = {exp_q[0].addr[31:OFF_W], 4'($urandom_range(0, 15))};
            else
                r_chk_addr = $urandom;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_line(input logic [31:0] a, input logic [WORDS-1:0][31:0] w);
        line_t ln;
        ln.addr = {a[31:OFF_W], 4'h0};
        ln.w    = w;
        exp_q.push_back(ln);
        bus.wb_addr = a;
        bus.wb_line = w;
        bus.wb_req  = 1'b1;
    endtask

    task automatic wait_accept();
        bit got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.wb_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("accept");
        step();
        bus.wb_req = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("drain");
        step();
    endtask

    initial begin
        logic [WORDS-1:0][31:0] basic_w;
        logic [WORDS-1:0][31:0] rw;
        int n;
        int ld0;
        int bt0;
        logic [6:0] pat;
        bit got;

        basic_w = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        bus.wb_req  = 1'b0;
        bus.wb_addr = '0;
        bus.wb_line = '0;
        reset = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_wb_ready", 32'(bus.wb_ready), 32'h1);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_wr_req", 32'(bus.wr_req), 32'h0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'h0);
        check("rst_wr_last", 32'(bus.wr_last), 32'h0);
        check("rst_wr_bready", 32'(bus.wr_bready), 32'h0);
        check("rst_wr_addr", bus.wr_addr, 32'h0);
        check("rst_wr_data", bus.wr_data, 32'h0);
        check("rst_chk_data", bus.chk_data, 32'h0);
        check("rst_chk_hit", 32'(bus.chk_hit), 32'h0);
        step();
        reset  = 1'b0;
        mon_en = 1'b1;

        // Basic burst, no stalls: accept-to-ready-again is 7 cycles
        d_wr_ready = 1'b1; d_wr_data_ready = 1'b1; d_wr_bvalid = 1'b1;
        offer_line(32'h1C00_0034, basic_w);
        wait_accept();
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("basic_wr_addr", bus.wr_addr, 32'h1C00_0030);
                check("basic_wr_len", 32'(bus.wr_len), 32'h3);
            end
            if (bus.wb_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("basic_ready");
        check("basic_latency", 32'(n), 32'd7);
        step();

        // Stray response in IDLE
        d_wr_ready = 1'b0; d_wr_data_ready = 1'b0; d_wr_bvalid = 1'b1;
        step();
        d_wr_bvalid = 1'b0;
        @(negedge clk);
        check("stray_idle_ready", 32'(bus.wb_ready), 32'h1);
        check("stray_idle_busy", 32'(bus.busy), 32'h0);
        step();

        // Stalls, hazard lookup and stray response during DATA
        ld0 = lines_done;
        bt0 = beats_total;
        offer_line(32'h1C00_0034, basic_w);
        wait_accept();
        for (int i = 0; i < 3; i++) begin
            d_chk_addr = (i == 0) ? 32'h1C00_0038 : 32'h1C00_0040;
            @(negedge clk);
            if (i == 0) begin
                check("hazard_hit", 32'(bus.chk_hit), 32'h1);
`ifdef WB_FORWARD_EN
                check("hazard_data", bus.chk_data, 32'h33333333);
`endif
            end else begin
                check("hazard_miss", 32'(bus.chk_hit), 32'h0);
            end
            step();
        end
        d_wr_ready = 1'b1;
        step();
        d_wr_ready = 1'b0;
        pat = 7'b1010101;
        for (int i = 0; i < 7; i++) begin
            d_wr_data_ready = pat[i];
            d_wr_bvalid     = !pat[i];
            step();
        end
        d_wr_data_ready = 1'b0;
        d_wr_bvalid     = 1'b0;
        step();
        d_wr_bvalid = 1'b1;
        step();
        d_wr_bvalid = 1'b0;
        d_chk_addr  = 32'h1C00_0038;
        @(negedge clk);
        check("stall_lines", 32'(lines_done - ld0), 32'd1);
        check("stall_beats", 32'(beats_total - bt0), 32'd4);
        check("post_resp_hit", 32'(bus.chk_hit), 32'h0);
        step();

        // Back-to-back: second line held from RESP, accepted on first IDLE cycle
        d_wr_ready = 1'b1; d_wr_data_ready = 1'b1; d_wr_bvalid = 1'b0;
        for (int k = 0; k < int'(WORDS); k++) rw[k] = $urandom;
        offer_line(32'h2000_0014, rw);
        wait_accept();
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.wr_bready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout("b2b_resp");
        step();
        for (int k = 0; k < int'(WORDS); k++) rw[k] = $urandom;
        offer_line(32'h2000_0024, rw);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("b2b_hold", 32'(bus.wb_ready), 32'h0);
            step();
        end
        d_wr_bvalid = 1'b1;
        wait_accept();
        wait_drain(100);

        // Reset after the second data beat, then a fresh burst from word 0
        d_wr_ready = 1'b1; d_wr_data_ready = 1'b1; d_wr_bvalid = 1'b1;
        d_chk_addr = 32'h3000_0040;
        for (int k = 0; k < int'(WORDS); k++) rw[k] = $urandom;
        offer_line(32'h3000_004C, rw);
        wait_accept();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.wr_valid), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        check("mid_rst_ready", 32'(bus.wb_ready), 32'h1);
        check("mid_rst_hit", 32'(bus.chk_hit), 32'h0);
        step();
        for (int k = 0; k < int'(WORDS); k++) rw[k] = $urandom;
        offer_line(32'h3000_0050, rw);
        wait_accept();
        wait_drain(100);

        // Randomized traffic against the scoreboard
        rand_rdy = 1'b1;
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 3)) step();
            for (int k = 0; k < int'(WORDS); k++) rw[k] = $urandom;
            offer_line($urandom, rw);
            wait_accept();
        end
        wait_drain(3000);
        rand_rdy = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
